// File: rtl/mips_control_unit_param_if.sv
// Control-unit bus: instruction fields and Zero in, datapath controls and status out.
interface mips_control_unit_param_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;

    logic       PCWrite;
    logic       IorD;
    logic       MemReadWrite;
    logic       IRWrite;
    logic       AluSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       AWrite;
    logic       BWrite;
    logic       AluOutWrite;
    logic       MDRWrite;
    logic [1:0] PCSource;
    logic [1:0] AluSrcB;
    logic [1:0] MemtoReg;
    logic [2:0] ALUOpOut;
    logic [5:0] State_out;
    logic       Halted;
    logic       IllegalOp;
    logic       InstrDone;

    modport master (
        input  opcode, funct, Zero,
        output PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite, RegDst,
               AWrite, BWrite, AluOutWrite, MDRWrite, PCSource, AluSrcB, MemtoReg,
               ALUOpOut, State_out, Halted, IllegalOp, InstrDone
    );

    modport slave (
        output opcode, funct, Zero,
        input  PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite, RegDst,
               AWrite, BWrite, AluOutWrite, MDRWrite, PCSource, AluSrcB, MemtoReg,
               ALUOpOut, State_out, Halted, IllegalOp, InstrDone
    );
endinterface

// File: rtl/mips_control_unit_param.sv
// Multicycle MIPS control FSM with a memory-latency wait counter, beq/bne on Zero
// and a selectable trap on unsupported instructions.
module mips_control_unit_param #(
    parameter int MEM_LATENCY     = 2,
    parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
    input logic                       clock,
    input logic                       reset,
    mips_control_unit_param_if.master bus
);
    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_NOP    = 6'h00;
    localparam logic [5:0] F_BREAK  = 6'h0D;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_XOR    = 6'h26;

    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd6;

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_DECODE     = 4'd2,
        S_ALU_EXEC   = 4'd3,
        S_ALU_WB     = 4'd4,
        S_MEM_ADDR   = 4'd5,
        S_MEM_ACCESS = 4'd6,
        S_LOAD_WB    = 4'd7,
        S_BRANCH     = 4'd8,
        S_LUI        = 4'd9,
        S_JUMP       = 4'd10,
        S_HALT       = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read_write;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       a_write;
        logic       b_write;
        logic       alu_out_write;
        logic       mdr_write;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_op;
        logic       halted;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    state_t           state;
    state_t           state_next;
    state_t           dec_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             wait_last;
    logic             dec_illegal;
    logic             dec_done;
    logic             is_store;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;

    assign wait_last = (cnt == CNT_LAST);
    assign is_store  = (bus.opcode == OP_SW);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Instruction classification used when leaving DECODE.
    always_comb begin
        dec_next    = S_FETCH;
        dec_illegal = 1'b0;
        dec_done    = 1'b0;
        if (bus.opcode == OP_RTYPE) begin
            case (bus.funct)
                F_ADD, F_SUB, F_AND, F_XOR: dec_next = S_ALU_EXEC;
                F_NOP:                      dec_done = 1'b1;
                F_BREAK:                    dec_next = S_HALT;
                default:                    dec_illegal = 1'b1;
            endcase
        end else begin
            case (bus.opcode)
                OP_LW, OP_SW:   dec_next = S_MEM_ADDR;
                OP_BEQ, OP_BNE: dec_next = S_BRANCH;
                OP_LUI:         dec_next = S_LUI;
                OP_J:           dec_next = S_JUMP;
                default:        dec_illegal = 1'b1;
            endcase
        end
        if (dec_illegal) begin
            if (TRAP_ON_ILLEGAL) begin
                dec_next = S_HALT;
            end else begin
                dec_done = 1'b1;
            end
        end
    end

    always_comb begin
        ctrl       = '0;
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_FETCH: begin
                cnt_next   = '0;
                state_next = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                cnt_next = cnt + CNT_W'(1);
                if (wait_last) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.alu_src_b = 2'b01;
                    ctrl.alu_op    = ALU_ADD;
                    state_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut latches the branch target while the register file is read.
                ctrl.alu_src_b     = 2'b11;
                ctrl.alu_op        = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
                ctrl.a_write       = 1'b1;
                ctrl.b_write       = 1'b1;
                ctrl.illegal_op    = dec_illegal;
                ctrl.instr_done    = dec_done;
                state_next         = dec_next;
            end
            S_ALU_EXEC: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_out_write = 1'b1;
                case (bus.funct)
                    F_SUB:   ctrl.alu_op = ALU_SUB;
                    F_AND:   ctrl.alu_op = ALU_AND;
                    F_XOR:   ctrl.alu_op = ALU_XOR;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = 2'b10;
                ctrl.alu_op        = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
                cnt_next           = '0;
                state_next         = S_MEM_ACCESS;
            end
            S_MEM_ACCESS: begin
                ctrl.iord           = 1'b1;
                ctrl.mem_read_write = is_store;
                cnt_next            = cnt + CNT_W'(1);
                if (wait_last) begin
                    if (is_store) begin
                        ctrl.instr_done = 1'b1;
                        state_next      = S_FETCH;
                    end else begin
                        ctrl.mdr_write  = 1'b1;
                        state_next      = S_LOAD_WB;
                    end
                end
            end
            S_LOAD_WB: begin
                ctrl.mem_to_reg = 2'b01;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_source  = 2'b01;
                ctrl.pc_write   = ((bus.opcode == OP_BEQ) &&  bus.Zero) ||
                                  ((bus.opcode == OP_BNE) && !bus.Zero);
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_LUI: begin
                ctrl.mem_to_reg = 2'b10;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_source  = 2'b10;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
                state_next  = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Every output is forced low for the whole reset cycle.
    assign ctrl_out = reset ? '0 : ctrl;

    assign bus.PCWrite      = ctrl_out.pc_write;
    assign bus.IorD         = ctrl_out.iord;
    assign bus.MemReadWrite = ctrl_out.mem_read_write;
    assign bus.IRWrite      = ctrl_out.ir_write;
    assign bus.AluSrcA      = ctrl_out.alu_src_a;
    assign bus.RegWrite     = ctrl_out.reg_write;
    assign bus.RegDst       = ctrl_out.reg_dst;
    assign bus.AWrite       = ctrl_out.a_write;
    assign bus.BWrite       = ctrl_out.b_write;
    assign bus.AluOutWrite  = ctrl_out.alu_out_write;
    assign bus.MDRWrite     = ctrl_out.mdr_write;
    assign bus.PCSource     = ctrl_out.pc_source;
    assign bus.AluSrcB      = ctrl_out.alu_src_b;
    assign bus.MemtoReg     = ctrl_out.mem_to_reg;
    assign bus.ALUOpOut     = ctrl_out.alu_op;
    assign bus.Halted       = ctrl_out.halted;
    assign bus.IllegalOp    = ctrl_out.illegal_op;
    assign bus.InstrDone    = ctrl_out.instr_done;
    assign bus.State_out    = reset ? 6'd0 : {2'b00, state};
endmodule

// File: tb/tb_mips_control_unit_param.sv
// Bench for mips_control_unit_param: per-cycle stimulus/expectation scoreboard against
// three instances (L=2 no trap, L=3 trap, L=1 no trap) sharing clock, reset and inputs.
module tb_mips_control_unit_param;
    typedef struct packed {
        logic       pcw, iord, mrw, irw, asa, rw, rdst, aw, bw, aow, mdrw;
        logic [1:0] pcs, asb, m2r;
        logic [2:0] aluop;
        logic       halted, ill, done;
        logic [5:0] st;
    } ctl_t;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        ctl_t       exp;
    } rec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    int n_checks = 0;
    int n_pass   = 0;

    rec_t       sb_q[$];
    logic       cur_rst = 1'b0;
    logic [5:0] cur_op  = 6'h00;
    logic [5:0] cur_fn  = 6'h00;
    logic       cur_z   = 1'b0;

    always #5 clock = ~clock;

    mips_control_unit_param_if if_a ();
    mips_control_unit_param_if if_b ();
    mips_control_unit_param_if if_c ();

    assign if_a.opcode = opcode;
    assign if_a.funct  = funct;
    assign if_a.Zero   = zero;
    assign if_b.opcode = opcode;
    assign if_b.funct  = funct;
    assign if_b.Zero   = zero;
    assign if_c.opcode = opcode;
    assign if_c.funct  = funct;
    assign if_c.Zero   = zero;

    mips_control_unit_param #(.MEM_LATENCY(2), .TRAP_ON_ILLEGAL(1'b0)) dut_a (
        .clock(clock), .reset(reset), .bus(if_a));
    mips_control_unit_param #(.MEM_LATENCY(3), .TRAP_ON_ILLEGAL(1'b1)) dut_b (
        .clock(clock), .reset(reset), .bus(if_b));
    mips_control_unit_param #(.MEM_LATENCY(1), .TRAP_ON_ILLEGAL(1'b0)) dut_c (
        .clock(clock), .reset(reset), .bus(if_c));

    ctl_t act_a, act_b, act_c;
    assign act_a = {if_a.PCWrite, if_a.IorD, if_a.MemReadWrite, if_a.IRWrite, if_a.AluSrcA,
                    if_a.RegWrite, if_a.RegDst, if_a.AWrite, if_a.BWrite, if_a.AluOutWrite,
                    if_a.MDRWrite, if_a.PCSource, if_a.AluSrcB, if_a.MemtoReg, if_a.ALUOpOut,
                    if_a.Halted, if_a.IllegalOp, if_a.InstrDone, if_a.State_out};
    assign act_b = {if_b.PCWrite, if_b.IorD, if_b.MemReadWrite, if_b.IRWrite, if_b.AluSrcA,
                    if_b.RegWrite, if_b.RegDst, if_b.AWrite, if_b.BWrite, if_b.AluOutWrite,
                    if_b.MDRWrite, if_b.PCSource, if_b.AluSrcB, if_b.MemtoReg, if_b.ALUOpOut,
                    if_b.Halted, if_b.IllegalOp, if_b.InstrDone, if_b.State_out};
    assign act_c = {if_c.PCWrite, if_c.IorD, if_c.MemReadWrite, if_c.IRWrite, if_c.AluSrcA,
                    if_c.RegWrite, if_c.RegDst, if_c.AWrite, if_c.BWrite, if_c.AluOutWrite,
                    if_c.MDRWrite, if_c.PCSource, if_c.AluSrcB, if_c.MemtoReg, if_c.ALUOpOut,
                    if_c.Halted, if_c.IllegalOp, if_c.InstrDone, if_c.State_out};

    // Expected per-state values, written from the state table.
    function automatic ctl_t mk(input int st);
        ctl_t e;
        e    = '0;
        e.st = 6'(st);
        return e;
    endfunction

    task automatic push(input ctl_t e);
        rec_t r;
        r.rst = cur_rst;
        r.op  = cur_op;
        r.fn  = cur_fn;
        r.z   = cur_z;
        r.exp = e;
        sb_q.push_back(r);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        cur_op = op;
        cur_fn = fn;
        cur_z  = z;
    endtask

    task automatic push_reset();
        cur_rst = 1'b1;
        push('0);
        cur_rst = 1'b0;
    endtask

    task automatic push_fetch(input int lat);
        ctl_t e;
        push(mk(0));
        for (int i = 0; i < lat; i++) begin
            e = mk(1);
            if (i == lat - 1) begin
                e.irw = 1'b1; e.pcw = 1'b1; e.asb = 2'b01; e.aluop = 3'd1;
            end
            push(e);
        end
    endtask

    task automatic push_decode(input logic ill, input logic done);
        ctl_t e;
        e = mk(2);
        e.asb = 2'b11; e.aluop = 3'd1; e.aow = 1'b1; e.aw = 1'b1; e.bw = 1'b1;
        e.ill = ill; e.done = done;
        push(e);
    endtask

    task automatic push_alu(input logic [2:0] aluop);
        ctl_t e;
        e = mk(3);
        e.asa = 1'b1; e.aow = 1'b1; e.aluop = aluop;
        push(e);
        e = mk(4);
        e.rdst = 1'b1; e.rw = 1'b1; e.done = 1'b1;
        push(e);
    endtask

    task automatic push_mem(input int lat, input logic store);
        ctl_t e;
        e = mk(5);
        e.asa = 1'b1; e.asb = 2'b10; e.aluop = 3'd1; e.aow = 1'b1;
        push(e);
        for (int i = 0; i < lat; i++) begin
            e = mk(6);
            e.iord = 1'b1; e.mrw = store;
            if (i == lat - 1) begin
                if (store) e.done = 1'b1;
                else       e.mdrw = 1'b1;
            end
            push(e);
        end
        if (!store) begin
            e = mk(7);
            e.m2r = 2'b01; e.rw = 1'b1; e.done = 1'b1;
            push(e);
        end
    endtask

    task automatic push_branch(input logic taken);
        ctl_t e;
        e = mk(8);
        e.asa = 1'b1; e.aluop = 3'd2; e.pcs = 2'b01; e.done = 1'b1; e.pcw = taken;
        push(e);
    endtask

    task automatic push_halt(input int n);
        ctl_t e;
        e = mk(11);
        e.halted = 1'b1;
        for (int i = 0; i < n; i++) push(e);
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'h02; funct = 6'h20; zero = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (act_a !== ctl_t'(0)) $display("FAIL reset_a cyc %0d: got %h need 0", k, act_a);
            else n_pass++;
            n_checks++;
            if (act_b !== ctl_t'(0)) $display("FAIL reset_b cyc %0d: got %h need 0", k, act_b);
            else n_pass++;
            n_checks++;
            if (act_c !== ctl_t'(0)) $display("FAIL reset_c cyc %0d: got %h need 0", k, act_c);
            else n_pass++;
            @(negedge clock);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h24, 6'h26};
        logic [2:0] ops[4] = '{3'd1, 3'd2, 3'd3, 3'd6};
        rec_t r;
        int   cyc = 0;
        push_reset();
        for (int i = 0; i < 4; i++) begin
            set_instr(6'h00, fns[i], 1'b0);
            push_fetch(2); push_decode(1'b0, 1'b0); push_alu(ops[i]);
        end
        set_instr(6'h00, 6'h00, 1'b0);
        push_fetch(2); push_decode(1'b0, 1'b1); push(mk(0));
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z;
            #1;
            n_checks++;
            if (act_a !== r.exp)
                $display("FAIL rtype cyc %0d: state %0d ctl %h, need state %0d ctl %h",
                         cyc, act_a.st, act_a, r.exp.st, r.exp);
            else n_pass++;
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_lw_sw();
        rec_t r;
        int   cyc = 0;
        push_reset();
        set_instr(6'h23, 6'h11, 1'b0);
        push_fetch(3); push_decode(1'b0, 1'b0); push_mem(3, 1'b0);
        set_instr(6'h2B, 6'h11, 1'b1);
        push_fetch(3); push_decode(1'b0, 1'b0); push_mem(3, 1'b1);
        push(mk(0));
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z;
            #1;
            n_checks++;
            if (act_b !== r.exp)
                $display("FAIL lw_sw cyc %0d: state %0d ctl %h, need state %0d ctl %h",
                         cyc, act_b.st, act_b, r.exp.st, r.exp);
            else n_pass++;
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_branch();
        logic [5:0] bops[4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic       zs[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       tk[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        rec_t r;
        int   cyc = 0;
        push_reset();
        for (int i = 0; i < 4; i++) begin
            set_instr(bops[i], 6'h2A, zs[i]);
            push_fetch(2); push_decode(1'b0, 1'b0); push_branch(tk[i]);
        end
        push(mk(0));
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z;
            #1;
            n_checks++;
            if (act_a !== r.exp)
                $display("FAIL branch cyc %0d: state %0d ctl %h, need state %0d ctl %h",
                         cyc, act_a.st, act_a, r.exp.st, r.exp);
            else n_pass++;
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_lui_jump();
        ctl_t e;
        rec_t r;
        int   cyc = 0;
        push_reset();
        set_instr(6'h0F, 6'h3F, 1'b0);
        push_fetch(2); push_decode(1'b0, 1'b0);
        e = mk(9); e.m2r = 2'b10; e.rw = 1'b1; e.done = 1'b1; push(e);
        set_instr(6'h02, 6'h00, 1'b1);
        push_fetch(2); push_decode(1'b0, 1'b0);
        e = mk(10); e.pcs = 2'b10; e.pcw = 1'b1; e.done = 1'b1; push(e);
        push(mk(0));
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z;
            #1;
            n_checks++;
            if (act_a !== r.exp)
                $display("FAIL lui_jump cyc %0d: state %0d ctl %h, need state %0d ctl %h",
                         cyc, act_a.st, act_a, r.exp.st, r.exp);
            else n_pass++;
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_halt();
        rec_t r;
        int   cyc = 0;
        push_reset();
        set_instr(6'h00, 6'h0D, 1'b0);
        push_fetch(2); push_decode(1'b0, 1'b0);
        set_instr(6'h23, 6'h20, 1'b1);
        push_halt(20);
        push_reset();
        push_fetch(2);
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z;
            #1;
            n_checks++;
            if (act_a !== r.exp)
                $display("FAIL halt cyc %0d: state %0d ctl %h, need state %0d ctl %h",
                         cyc, act_a.st, act_a, r.exp.st, r.exp);
            else n_pass++;
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_illegal();
        rec_t r;
        int   cyc = 0;
        push_reset();
        set_instr(6'h3F, 6'h20, 1'b0);
        push_fetch(2); push_decode(1'b1, 1'b1);
        set_instr(6'h00, 6'h3F, 1'b0);
        push_fetch(2); push_decode(1'b1, 1'b1);
        push(mk(0));
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z;
            #1;
            n_checks++;
            if (act_a !== r.exp)
                $display("FAIL illegal_skip cyc %0d: state %0d ctl %h, need state %0d ctl %h",
                         cyc, act_a.st, act_a, r.exp.st, r.exp);
            else n_pass++;
            cyc++;
            @(negedge clock);
        end
        cyc = 0;
        push_reset();
        set_instr(6'h3F, 6'h20, 1'b0);
        push_fetch(3); push_decode(1'b1, 1'b0); push_halt(3);
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z;
            #1;
            n_checks++;
            if (act_b !== r.exp)
                $display("FAIL illegal_trap cyc %0d: state %0d ctl %h, need state %0d ctl %h",
                         cyc, act_b.st, act_b, r.exp.st, r.exp);
            else n_pass++;
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_sw();
        ctl_t e;
        rec_t r;
        int   cyc = 0;
        push_reset();
        set_instr(6'h2B, 6'h00, 1'b0);
        push_fetch(3); push_decode(1'b0, 1'b0);
        e = mk(5); e.asa = 1'b1; e.asb = 2'b10; e.aluop = 3'd1; e.aow = 1'b1; push(e);
        e = mk(6); e.iord = 1'b1; e.mrw = 1'b1; push(e);
        push_reset();
        push_fetch(3); push_decode(1'b0, 1'b0); push_mem(3, 1'b1);
        push(mk(0));
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z;
            #1;
            n_checks++;
            if (act_b !== r.exp)
                $display("FAIL reset_mid_sw cyc %0d: state %0d ctl %h, need state %0d ctl %h",
                         cyc, act_b.st, act_b, r.exp.st, r.exp);
            else n_pass++;
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_latency_one();
        rec_t r;
        int   cyc = 0;
        push_reset();
        set_instr(6'h00, 6'h26, 1'b0);
        push_fetch(1); push_decode(1'b0, 1'b0); push_alu(3'd6);
        set_instr(6'h23, 6'h00, 1'b0);
        push_fetch(1); push_decode(1'b0, 1'b0); push_mem(1, 1'b0);
        set_instr(6'h2B, 6'h00, 1'b0);
        push_fetch(1); push_decode(1'b0, 1'b0); push_mem(1, 1'b1);
        push(mk(0));
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            reset = r.rst; opcode = r.op; funct = r.fn; zero = r.z;
            #1;
            n_checks++;
            if (act_c !== r.exp)
                $display("FAIL latency_one cyc %0d: state %0d ctl %h, need state %0d ctl %h",
                         cyc, act_c.st, act_c, r.exp.st, r.exp);
            else n_pass++;
            cyc++;
            @(negedge clock);
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
        @(negedge clock);
        test_reset();
        test_rtype();
        test_lw_sw();
        test_branch();
        test_lui_jump();
        test_halt();
        test_illegal();
        test_reset_mid_sw();
        test_latency_one();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mips_control_unit_param.md
Name: mips_control_unit_param

Overview:
Parametrised successor to the multicycle MIPS control FSM. It replaces hard-coded memory wait states with a latency counter (MEM_LATENCY) and adds beq/bne branching driven by a real Zero input. It also adds a selectable illegal-opcode trap mode and status outputs (Halted, IllegalOp, InstrDone) for the bench. It drives the existing datapath mux and enable signals unchanged.

Parameters:
MEM_LATENCY, 2, memory wait cycles per access (≥1); wait counter width is $clog2(MEM_LATENCY+1).
TRAP_ON_ILLEGAL, 0, 1 = illegal opcode/funct enters HALT; 0 = flag it and skip to FETCH.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag, combinational from datapath
PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite, RegDst, AWrite, BWrite, AluOutWrite, MDRWrite  out  1 each  datapath controls (MemReadWrite: 0 = read, 1 = write)
PCSource, AluSrcB, MemtoReg  out  2 each  datapath mux selects
ALUOpOut  out  3  LOAD=0 ADD=1 SUB=2 AND=3 INC=4 NEG=5 XOR=6 COMP=7
State_out  out  6  state code, zero-extended
Halted  out  1  high while in HALT
IllegalOp  out  1  one-cycle pulse in DECODE on an unsupported instruction
InstrDone  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Reset is sampled on the clock edge. State goes to FETCH and wait counter to 0. While reset is high, every output is 0.
- Defaults for any signal not listed in a state: enables 0, mux selects 0, ALUOp LOAD. No X outputs.
- State codes: FETCH=0, FETCH_WAIT=1, DECODE=2, ALU_EXEC=3, ALU_WB=4, MEM_ADDR=5, MEM_ACCESS=6, LOAD_WB=7, BRANCH=8, LUI=9, JUMP=10, HALT=11.
- FETCH: IorD=0, read. Counter is cleared. Next state FETCH_WAIT.
- FETCH_WAIT: IorD=0, read. Counter increments each cycle and the state stays for MEM_LATENCY cycles.
  - On the last cycle: IRWrite=1, PCWrite=1, PCSource=00, AluSrcA=0, AluSrcB=01, ADD (PC<=PC+4).
  - Next state DECODE.
- DECODE: AluSrcA=0, AluSrcB=11, ADD, AluOutWrite=1 (branch target = PC+4+imm<<2). AWrite=BWrite=1.
  - opcode 0x00 with funct 0x20/0x22/0x24/0x26 -> ALU_EXEC.
  - opcode 0x00 with funct 0x00 (nop) -> FETCH, InstrDone=1.
  - opcode 0x00 with funct 0x0D (break) -> HALT.
  - opcode 0x23/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x0F -> LUI; 0x02 -> JUMP.
  - Anything else: IllegalOp=1, then HALT if TRAP_ON_ILLEGAL else FETCH with InstrDone=1.
- ALU_EXEC: AluSrcA=1, AluSrcB=00, AluOutWrite=1. ALUOp from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x26 XOR. Next state ALU_WB.
- ALU_WB: RegDst=1, MemtoReg=00, RegWrite=1, InstrDone=1. Next state FETCH.
- MEM_ADDR: AluSrcA=1, AluSrcB=10, ADD, AluOutWrite=1. Counter is cleared. Next state MEM_ACCESS.
- MEM_ACCESS: IorD=1 for MEM_LATENCY cycles.
  - lw: MemReadWrite=0; MDRWrite=1 on the last cycle only; then LOAD_WB.
  - sw: MemReadWrite=1 every cycle; InstrDone=1 on the last cycle; then FETCH.
- LOAD_WB: RegDst=0, MemtoReg=01, RegWrite=1, InstrDone=1. Next state FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, SUB, PCSource=01, InstrDone=1. Next state FETCH.
  - PCWrite = (opcode==0x04 & Zero) | (opcode==0x05 & ~Zero), evaluated combinationally in this same cycle.
- LUI: RegDst=0, MemtoReg=10, RegWrite=1, InstrDone=1. Next state FETCH.
- JUMP: PCSource=10, PCWrite=1, InstrDone=1. Next state FETCH.
- HALT: all controls 0, Halted=1. Only reset leaves HALT.
- Latency in cycles, FETCH through final state (L = MEM_LATENCY):
  - R-type: L+4
  - lw: 2L+4
  - sw: 2L+3
  - branch, lui, j: L+3
  - nop: L+2
- Counter never exceeds MEM_LATENCY. With L=1 each wait state lasts exactly one cycle and also carries the last-cycle signals.
- Reset in any state, including mid-MEM_ACCESS or HALT, returns to FETCH on the next edge. No write enable is asserted during the reset cycle.

Test Plan:
- L=2, add (op 0, funct 0x20) -> State_out 0,1,1,2,3,4; IRWrite+PCWrite on cycle 3; ALUOpOut=1 in ALU_EXEC; RegWrite with RegDst=1 in cycle 6; InstrDone on cycle 6 only.
- L=3, lw (0x23) -> 10 cycles; MDRWrite high only on the 3rd MEM_ACCESS cycle; IorD=1 throughout MEM_ACCESS. Then sw (0x2B) -> MemReadWrite=1 for 3 cycles, 9 cycles total.
- beq with Zero=1 -> PCWrite=1, PCSource=01. beq with Zero=0 -> PCWrite=0. bne with Zero=0 -> PCWrite=1. Each takes L+3 cycles.
- break (op 0, funct 0x0D) -> Halted=1 and State_out=11 held for 20 cycles with all controls 0. Reset -> State_out=0 next cycle.
- opcode 0x3F -> IllegalOp pulse in DECODE. TRAP_ON_ILLEGAL=0: FETCH next. TRAP_ON_ILLEGAL=1: HALT.
- Reset asserted in the 2nd MEM_ACCESS cycle of sw -> all outputs 0 during the reset cycle, then State_out=0 and a clean fetch follows.
